hist_eq_lut: RTL and testbench
==============================

# hist_eq_lut

Consumer of the CDF table in scratch memory. The block reads the 256 cumulative counts that the CDF stage left at words 64..127. It turns them into the 8-bit histogram-equalization lookup table lut[v] = round((cdf[v] − cdf_min)·255 / (TOTAL_PIXELS − cdf_min)), using a small sequential divider. It packs 16 LUT bytes per 128-bit word and writes them back to scratch memory at words 128..143, where the pixel-remap stage picks them up.

## Interface
- TOTAL_PIXELS, 8294400 — pixel count of the frame (3840×2160); equals cdf[255].
- CDF_BASE, 16'd64 — scratch word holding cdf[0..3].
- LUT_BASE, 16'd128 — scratch word receiving lut[0..15].
- READ_LATENCY, 2 — cycles from ReadAddress1 change to valid data on scratchmem_input1.
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; begins a LUT build when idle.
- cdf_min  in  32  first nonzero CDF value, from the CDF stage; sampled on start.
- scratchmem_input1  in  128  read data, 4 × 32-bit CDF entries, cdf[4k] in [127:96].
- ReadAddress1  out  16  scratch read address.
- WE  out  1  write strobe, one cycle per LUT word.
- WriteAddress  out  16  scratch write address.
- WriteBus  out  128  16 LUT bytes; lut[16j] in [127:120], lut[16j+15] in [7:0].
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse after the last write.

## Operation
- Reset values: all outputs 0; FSM in IDLE; internal counters cleared.
- FSM states: IDLE → ISSUE → WAIT → COMPUTE → (WRITE) → ISSUE … → FINISH → IDLE.
- IDLE
  - On start: latch cdf_min.
  - den = TOTAL_PIXELS − cdf_min (32-bit); set word index k = 0.
  - Go to ISSUE. start is ignored in every other state.
- ISSUE: ReadAddress1 = CDF_BASE + k; go to WAIT.
- WAIT: hold for READ_LATENCY cycles, then capture scratchmem_input1 into a 128-bit holding register.
- COMPUTE: process the 4 entries in order, MSB lane first, 9 cycles each.
  - Setup cycle: d = cdf − cdf_min, saturated to 0 if cdf < cdf_min.
  - num = d·255 + (den >> 1); 32-bit, cannot overflow since d ≤ den < 2^24.
  - Then 8 restoring-divide iterations produce an 8-bit quotient, which is stored into byte lane (v mod 16) of the LUT word register.
  - A quotient is guaranteed < 256 because num < 256·den.
- Degenerate case den == 0 (single-valued image): lut[v] = v. The divider is bypassed, but the same 9 cycles are spent so timing is identical.
- After the 4th entry:
  - If (k mod 4) == 3: go to WRITE.
  - Else: k = k+1, go to ISSUE.
- WRITE: for one cycle drive WE = 1, WriteAddress = LUT_BASE + k/4, WriteBus = LUT word register.
  - If k == 63, go to FINISH.
  - Else k = k+1, go to ISSUE.
- FINISH: done = 1 for one cycle, busy = 0; go to IDLE. WriteAddress and WriteBus hold their last values.
- Reset mid-operation: next cycle WE = 0, busy = 0, state IDLE. No partial word is written.

## Timing
- start at cycle 0 → ISSUE at cycle 1; ReadAddress1 valid from cycle 1.
- Per CDF word: 1 (ISSUE) + READ_LATENCY + 36 (COMPUTE) = 39 cycles with READ_LATENCY = 2.
- Plus 1 WRITE cycle every 4th word.
- First WE at cycle 1 + 4·39 = 157.
- Last WE at cycle 64·39 + 16 = 2512; done at cycle 2513.
- WE is never high on two consecutive cycles. ReadAddress1 is stable for the whole ISSUE..COMPUTE span of each word.

## Structure
- Shared package holds:
  - address constants CDF_BASE, LUT_BASE, CDF_WORDS = 64, LUT_WORDS = 16;
  - lane widths (CDF_W = 32, LUT_W = 8);
  - the FSM state encoding.
- Sub-module lut_div8: 8-iteration restoring divider.
  - Ports: clk, reset, load, num[31:0], den[31:0], quot[7:0], valid.
  - valid pulses 8 cycles after load.

## Test plan
- Uniform histogram (cdf[v] = 32400·(v+1), cdf_min = 32400) → lut[v] = v; word 128 = 0x000102…0F, word 143 = 0xF0F1…FF.
- Two-level image (cdf[0..254] = 4147200, cdf[255] = 8294400, cdf_min = 4147200) → lut[0..254] = 0, lut[255] = 255; word 143 = 0x00…00FF.
- Single-valued image (cdf[v] = 0 for v < 100, 8294400 otherwise; cdf_min = 8294400) → den = 0 → identity LUT, same 2513-cycle run.
- Check that ReadAddress1 steps 64..127 once each, WE asserts exactly 16 times at addresses 128..143, first WE at cycle 157, done at cycle 2513.
- start re-pulsed at cycle 500 → ignored; output identical to the single-start run.
- reset at cycle 1000 → WE/busy = 0 next cycle, no further writes; a fresh start then completes a full correct run.

Source files
------------

// File: rtl/hist_eq_lut_pkg.sv
// Shared constants and FSM encoding for the histogram-equalization LUT builder.
package hist_eq_lut_pkg;

  localparam logic [31:0] TOTAL_PIXELS = 32'd8294400;
  localparam logic [15:0] CDF_BASE     = 16'd64;
  localparam logic [15:0] LUT_BASE     = 16'd128;
  localparam int          CDF_WORDS    = 64;
  localparam int          LUT_WORDS    = 16;
  localparam int          CDF_W        = 32;
  localparam int          LUT_W        = 8;
  localparam int          READ_LATENCY = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_COMPUTE,
    S_WRITE,
    S_FINISH
  } state_t;

endpackage

// File: rtl/hist_eq_lut_div8.sv
// 8-iteration restoring divider; the quotient must fit in 8 bits (num < 256*den).
module lut_div8 (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] num,
  input  logic [31:0] den,
  output logic [7:0]  quot,
  output logic        valid
);

  logic [31:0] r_rem;
  logic [6:0]  r_low;
  logic [7:0]  r_quot;
  logic [2:0]  r_cnt;
  logic        r_valid;

  logic [31:0] w_rem_in;
  logic        w_bit_in;
  logic [32:0] w_trial;
  logic        w_ge;
  logic [31:0] w_rem_next;

  // The load cycle already performs the first iteration, so the result lands 8 cycles later.
  always_comb begin
    w_rem_in   = load ? {8'd0, num[31:8]} : r_rem;
    w_bit_in   = load ? num[7] : r_low[6];
    w_trial    = {w_rem_in, w_bit_in};
    w_ge       = (w_trial >= {1'b0, den});
    w_rem_next = w_ge ? 32'(w_trial - {1'b0, den}) : w_trial[31:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem   <= '0;
      r_low   <= '0;
      r_quot  <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (load) begin
        r_rem  <= w_rem_next;
        r_low  <= num[6:0];
        r_quot <= {7'd0, w_ge};
        r_cnt  <= 3'd7;
      end else if (r_cnt != 3'd0) begin
        r_rem   <= w_rem_next;
        r_low   <= {r_low[5:0], 1'b0};
        r_quot  <= {r_quot[6:0], w_ge};
        r_cnt   <= r_cnt - 3'd1;
        r_valid <= (r_cnt == 3'd1);
      end
    end
  end

  assign quot  = r_quot;
  assign valid = r_valid;

endmodule

// File: rtl/hist_eq_lut.sv
// Reads the 256-entry CDF from scratch memory and writes back the 8-bit equalization LUT.
module hist_eq_lut
  import hist_eq_lut_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [31:0]  cdf_min,
  input  logic [127:0] scratchmem_input1,
  output logic [15:0]  ReadAddress1,
  output logic         WE,
  output logic [15:0]  WriteAddress,
  output logic [127:0] WriteBus,
  output logic         busy,
  output logic         done
);

  state_t         r_state, w_next;
  logic [31:0]    r_cdf_min;
  logic [31:0]    r_den;
  logic [5:0]     r_k;
  logic [1:0]     r_wait;
  logic [127:0]   r_hold;
  logic [1:0]     r_lane;
  logic           r_setup;
  logic [127:0]   r_lut;
  logic [15:0]    r_raddr;
  logic [15:0]    r_waddr;

  logic           w_wait_last;
  logic [CDF_W-1:0] w_cdf;
  logic [31:0]    w_d;
  logic [31:0]    w_num;
  logic           w_div_load;
  logic [7:0]     w_quot;
  logic           w_div_valid;
  logic [3:0]     w_byte_idx;
  logic [LUT_W-1:0] w_lut_byte;

  assign w_wait_last = (r_wait == 2'(READ_LATENCY - 1));
  assign w_cdf       = r_hold[{~r_lane, 5'b00000} +: CDF_W];
  assign w_d         = (w_cdf >= r_cdf_min) ? (w_cdf - r_cdf_min) : 32'd0;
  assign w_num       = (w_d << 8) - w_d + (r_den >> 1);
  assign w_div_load  = (r_state == S_COMPUTE) && r_setup;
  assign w_byte_idx  = {r_k[1:0], r_lane};
  // A zero denominator means a single-valued image: emit the identity mapping instead.
  assign w_lut_byte  = (r_den == 32'd0) ? {r_k, r_lane} : w_quot;

  lut_div8 u_div (
    .clk   (clk),
    .reset (reset),
    .load  (w_div_load),
    .num   (w_num),
    .den   (r_den),
    .quot  (w_quot),
    .valid (w_div_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    WE     = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE:    if (start) w_next = S_ISSUE;
      S_ISSUE: begin
        busy   = 1'b1;
        w_next = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (w_wait_last) w_next = S_COMPUTE;
      end
      S_COMPUTE: begin
        busy = 1'b1;
        if (w_div_valid && r_lane == 2'd3)
          w_next = (r_k[1:0] == 2'd3) ? S_WRITE : S_ISSUE;
      end
      S_WRITE: begin
        busy   = 1'b1;
        WE     = 1'b1;
        w_next = (r_k == 6'(CDF_WORDS - 1)) ? S_FINISH : S_ISSUE;
      end
      S_FINISH: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cdf_min <= '0;
      r_den     <= '0;
      r_k       <= '0;
      r_wait    <= '0;
      r_hold    <= '0;
      r_lane    <= '0;
      r_setup   <= 1'b0;
      r_lut     <= '0;
      r_raddr   <= '0;
      r_waddr   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cdf_min <= cdf_min;
            r_den     <= TOTAL_PIXELS - cdf_min;
            r_k       <= '0;
            r_raddr   <= CDF_BASE;
          end
        end
        S_ISSUE: r_wait <= '0;
        S_WAIT: begin
          r_wait <= r_wait + 2'd1;
          if (w_wait_last) begin
            r_hold  <= scratchmem_input1;
            r_lane  <= '0;
            r_setup <= 1'b1;
          end
        end
        S_COMPUTE: begin
          r_setup <= 1'b0;
          if (w_div_valid) begin
            r_lut[{~w_byte_idx, 3'b000} +: LUT_W] <= w_lut_byte;
            r_lane  <= r_lane + 2'd1;
            r_setup <= (r_lane != 2'd3);
            if (r_lane == 2'd3) begin
              if (r_k[1:0] == 2'd3) begin
                r_waddr <= LUT_BASE + 16'(r_k[5:2]);
              end else begin
                r_k     <= r_k + 6'd1;
                r_raddr <= CDF_BASE + 16'(r_k) + 16'd1;
              end
            end
          end
        end
        S_WRITE: begin
          if (r_k != 6'(CDF_WORDS - 1)) begin
            r_k     <= r_k + 6'd1;
            r_raddr <= CDF_BASE + 16'(r_k) + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ReadAddress1 = r_raddr;
  assign WriteAddress = r_waddr;
  assign WriteBus     = r_lut;

endmodule

// File: tb/tb_hist_eq_lut.sv
// Directed bench for hist_eq_lut: scratch-memory model with 2-cycle read latency and hand-derived LUTs.
module tb_hist_eq_lut;

  logic         clk;
  logic         reset;
  logic         start;
  logic [31:0]  cdf_min;
  logic [127:0] scratchmem_input1;
  logic [15:0]  ReadAddress1;
  logic         WE;
  logic [15:0]  WriteAddress;
  logic [127:0] WriteBus;
  logic         busy;
  logic         done;

  logic [127:0] mem [256];
  logic [15:0]  rdA;
  int unsigned  cdfTab [256];
  logic [7:0]   expLut [256];

  int nPass;
  int nChecks;

  int           weCount, firstWe, doneCyc, raSteps, consecWe, postResetWe;
  logic         waddrOk, raOrderOk, busyAt1, busyAtDone;
  logic [1:0]   resetSample;
  logic [127:0] words [16];

  hist_eq_lut dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .cdf_min           (cdf_min),
    .scratchmem_input1 (scratchmem_input1),
    .ReadAddress1      (ReadAddress1),
    .WE                (WE),
    .WriteAddress      (WriteAddress),
    .WriteBus          (WriteBus),
    .busy              (busy),
    .done              (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two register stages between address and data give the 2-cycle read latency.
  always @(posedge clk) begin
    rdA               <= ReadAddress1;
    scratchmem_input1 <= mem[rdA[7:0]];
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic loadMem();
    for (int i = 0; i < 256; i++) mem[i] = '0;
    for (int v = 0; v < 256; v++)
      mem[64 + v / 4][127 - 32 * (v % 4) -: 32] = cdfTab[v];
  endtask

  task automatic applyStimulus(input int repulseAt, input int resetAt);
    int cyc;
    int stopAt;
    logic prevWe;
    logic [15:0] prevRa;
    weCount = 0; firstWe = -1; doneCyc = -1; raSteps = 0; consecWe = 0; postResetWe = 0;
    waddrOk = 1'b1; raOrderOk = 1'b1; busyAt1 = 1'b0; busyAtDone = 1'b1; resetSample = 2'b11;
    for (int j = 0; j < 16; j++) words[j] = '0;
    stopAt = (resetAt > 0) ? resetAt + 50 : 3000;
    @(negedge clk);
    prevRa = ReadAddress1;
    prevWe = 1'b0;
    start  = 1'b1;
    cyc    = 0;
    while (doneCyc < 0 && cyc < stopAt) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) busyAt1 = busy;
      if (WE) begin
        if (resetAt > 0 && cyc > resetAt) postResetWe++;
        else begin
          if (weCount == 0) firstWe = cyc;
          if (WriteAddress != 16'(128 + weCount)) waddrOk = 1'b0;
          if (weCount < 16) words[weCount] = WriteBus;
          weCount++;
        end
        if (prevWe) consecWe++;
      end
      prevWe = WE;
      if ((resetAt == 0 || cyc <= resetAt) && ReadAddress1 != prevRa) begin
        if (ReadAddress1 != 16'(64 + raSteps)) raOrderOk = 1'b0;
        raSteps++;
        prevRa = ReadAddress1;
      end
      if (resetAt > 0 && cyc == resetAt + 1) resetSample = {WE, busy};
      if (done) begin
        doneCyc    = cyc;
        busyAtDone = busy;
      end
      start = (cyc == repulseAt);
      reset = (resetAt > 0 && cyc == resetAt);
    end
    start = 1'b0;
    reset = 1'b0;
  endtask

  task automatic checkRun(input string name);
    logic [127:0] w;
    checkOutput({name, " done cycle"}, 128'(doneCyc), 128'(2513));
    checkOutput({name, " first WE cycle"}, 128'(firstWe), 128'(157));
    checkOutput({name, " WE count"}, 128'(weCount), 128'(16));
    checkOutput({name, " write addresses"}, 128'(waddrOk), 128'(1));
    checkOutput({name, " read address steps"}, 128'(raSteps), 128'(64));
    checkOutput({name, " read address order"}, 128'(raOrderOk), 128'(1));
    checkOutput({name, " consecutive WE"}, 128'(consecWe), 128'(0));
    checkOutput({name, " busy at cycle 1"}, 128'(busyAt1), 128'(1));
    checkOutput({name, " busy at done"}, 128'(busyAtDone), 128'(0));
    for (int j = 0; j < 16; j++) begin
      w = '0;
      for (int i = 0; i < 16; i++) w = {w[119:0], expLut[16 * j + i]};
      checkOutput($sformatf("%s word%0d", name, 128 + j), words[j], w);
    end
  endtask

  initial begin
    nPass = 0; nChecks = 0;
    start = 1'b0; reset = 1'b1; cdf_min = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset WE", 128'(WE), 128'(0));
    checkOutput("reset busy", 128'(busy), 128'(0));
    checkOutput("reset done", 128'(done), 128'(0));
    checkOutput("reset ReadAddress1", 128'(ReadAddress1), 128'(0));
    checkOutput("reset WriteAddress", 128'(WriteAddress), 128'(0));
    checkOutput("reset WriteBus", WriteBus, 128'(0));
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] uniform histogram");
    for (int v = 0; v < 256; v++) begin
      cdfTab[v] = 32400 * (v + 1);
      expLut[v] = 8'(v);
    end
    loadMem();
    cdf_min = 32'd32400;
    applyStimulus(0, 0);
    checkRun("uniform");
    checkOutput("uniform word128 const", words[0], 128'h000102030405060708090A0B0C0D0E0F);
    checkOutput("uniform word143 const", words[15], 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF);

    $display("[TB] uniform with start re-pulsed at cycle 500");
    applyStimulus(500, 0);
    checkRun("repulse");

    $display("[TB] two-level image");
    for (int v = 0; v < 256; v++) begin
      cdfTab[v] = (v < 255) ? 4147200 : 8294400;
      expLut[v] = (v < 255) ? 8'd0 : 8'd255;
    end
    loadMem();
    cdf_min = 32'd4147200;
    applyStimulus(0, 0);
    checkRun("twolevel");
    checkOutput("twolevel word143 const", words[15], 128'h000000000000000000000000000000FF);

    $display("[TB] half-step ramp (den = 510)");
    for (int v = 0; v < 256; v++) begin
      cdfTab[v] = (v < 255) ? 8293890 + v : 8294400;
      expLut[v] = (v < 255) ? 8'((v + 1) >> 1) : 8'd255;
    end
    loadMem();
    cdf_min = 32'd8293890;
    applyStimulus(0, 0);
    checkRun("ramp");
    checkOutput("ramp word128 const", words[0], 128'h00010102020303040405050606070708);
    checkOutput("ramp word143 const", words[15], 128'h7879797A7A7B7B7C7C7D7D7E7E7F7FFF);

    $display("[TB] single-valued image, reset at cycle 1000");
    for (int v = 0; v < 256; v++) begin
      cdfTab[v] = (v < 100) ? 0 : 8294400;
      expLut[v] = 8'(v);
    end
    loadMem();
    cdf_min = 32'd8294400;
    applyStimulus(0, 1000);
    checkOutput("reset-run WE/busy after reset", 128'(resetSample), 128'(0));
    checkOutput("reset-run writes before reset", 128'(weCount), 128'(6));
    checkOutput("reset-run writes after reset", 128'(postResetWe), 128'(0));
    checkOutput("reset-run no done", 128'(doneCyc), 128'(-1));

    $display("[TB] single-valued image, fresh start");
    applyStimulus(0, 0);
    checkRun("single");

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
